// File: rtl/dht11_request_scheduler.sv
// Round-robin scheduler sharing one DHT11 sensor FSM among N_REQ requesters, with an
// enforced idle gap after every sensor read and a watchdog on unresponsive reads.
module dht11_request_scheduler #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int MIN_GAP_CYC = 100_000_000,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [2*N_REQ-1:0] req_code,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [7:0]         resp_data,
  output logic               resp_error,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic [1:0]         sens_request,
  input  logic [7:0]         sens_information,
  input  logic               sens_done,
  output logic [2:0]         fsm_state
);

  // Handshake: requester i raises req_valid[i] with req_code held stable and keeps it
  // until resp_valid[i] pulses; the pulse is the only acknowledgement. A request still
  // held after its pulse is treated as a new request and re-enters round-robin.

  localparam int MAX_CYC = (MIN_GAP_CYC > TIMEOUT_CYC) ? MIN_GAP_CYC : TIMEOUT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(N_REQ);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(MIN_GAP_CYC - 1);
  localparam logic [1:0]    NO_REQ       = 2'b11;
  localparam logic [1:0]    CODE_STATUS  = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    RESPOND   = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [ID_W-1:0] rr_ptr, rr_ptr_n;
  logic [ID_W-1:0] grant_n;
  logic [1:0]      code_q, code_n;
  logic [7:0]      result_q, result_n;
  logic            err_q, err_n;
  logic [1:0]      sens_request_n;
  logic [N_REQ-1:0] resp_valid_n;
  logic [7:0]      resp_data_n;
  logic            resp_error_n;

  logic [1:0]      code_arr [N_REQ];
  logic            hit;
  logic [IW-1:0]   scan_idx;
  logic [ID_W-1:0] pick_id;
  logic [1:0]      pick_code;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_code
      assign code_arr[g] = req_code[2*g+1 -: 2];
    end
  endgenerate

  // Scan starts one past the last grant so every requester is reached within N_REQ grants.
  always_comb begin
    hit       = 1'b0;
    scan_idx  = '0;
    pick_id   = '0;
    pick_code = NO_REQ;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = IW'((int'(rr_ptr) + i) % N_REQ);
      if (!hit && req_valid[scan_idx]) begin
        hit       = 1'b1;
        pick_id   = ID_W'(scan_idx);
        pick_code = code_arr[scan_idx];
      end
    end
  end

  always_comb begin
    state_n        = state;
    timer_n        = timer;
    rr_ptr_n       = rr_ptr;
    grant_n        = grant_id;
    code_n         = code_q;
    result_n       = result_q;
    err_n          = err_q;
    sens_request_n = sens_request;
    resp_valid_n   = '0;
    resp_data_n    = resp_data;
    resp_error_n   = resp_error;

    case (state)
      IDLE: begin
        sens_request_n = NO_REQ;
        if (hit) begin
          grant_n  = pick_id;
          rr_ptr_n = pick_id;
          code_n   = pick_code;
          timer_n  = '0;
          if (pick_code == NO_REQ) begin
            result_n = 8'hFF;
            err_n    = 1'b1;
            state_n  = RESPOND;
          end else begin
            sens_request_n = pick_code;
            state_n        = ISSUE;
          end
        end
      end

      ISSUE, WAIT_DONE: begin
        timer_n = timer + 1'b1;
        // Watchdog wins over a done flag arriving on the same cycle.
        if (timer == TIMEOUT_LAST) begin
          sens_request_n = NO_REQ;
          result_n       = 8'hFF;
          err_n          = 1'b1;
          timer_n        = '0;
          state_n        = RESPOND;
        end else if (state == ISSUE) begin
          if (!sens_done) state_n = WAIT_DONE;
        end else if (sens_done) begin
          sens_request_n = NO_REQ;
          result_n       = sens_information;
          err_n          = (code_q == CODE_STATUS) && (sens_information == 8'hFF);
          state_n        = RESPOND;
        end
      end

      RESPOND: begin
        sens_request_n = NO_REQ;
        resp_valid_n   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
        resp_data_n    = result_q;
        resp_error_n   = err_q;
        timer_n        = '0;
        state_n        = (code_q == NO_REQ) ? IDLE : GAP;
      end

      GAP: begin
        sens_request_n = NO_REQ;
        timer_n        = timer + 1'b1;
        if (timer == GAP_LAST) begin
          timer_n = '0;
          state_n = IDLE;
        end
      end

      default: begin
        sens_request_n = NO_REQ;
        timer_n        = '0;
        state_n        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      rr_ptr       <= ID_W'(N_REQ - 1);
      grant_id     <= '0;
      code_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      sens_request <= NO_REQ;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_error   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      rr_ptr       <= rr_ptr_n;
      grant_id     <= grant_n;
      code_q       <= code_n;
      result_q     <= result_n;
      err_q        <= err_n;
      sens_request <= sens_request_n;
      resp_valid   <= resp_valid_n;
      resp_data    <= resp_data_n;
      resp_error   <= resp_error_n;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_dht11_request_scheduler.sv
// Directed bench for dht11_request_scheduler: table of single transactions plus
// hand-written sequences for round-robin, mid-read reset and dropped req_valid.
module tb_dht11_request_scheduler;

  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int MIN_GAP    = 20;
  localparam int TIMEOUT    = 100;
  localparam int SENSOR_LAT = 30;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N_REQ-1:0] req_valid = '0;
  logic [1:0]       code_in [N_REQ];
  logic [2*N_REQ-1:0] req_code;
  logic [N_REQ-1:0] resp_valid;
  logic [7:0]       resp_data;
  logic             resp_error;
  logic             busy;
  logic [ID_W-1:0]  grant_id;
  logic [1:0]       sens_request;
  logic [7:0]       sens_information = 8'h00;
  logic             sens_done = 1'b1;
  logic [2:0]       fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic       never_done = 1'b0;
  logic [7:0] model_data = 8'h00;
  int         model_cnt  = 0;

  assign req_code = {code_in[3], code_in[2], code_in[1], code_in[0]};

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  dht11_request_scheduler #(
    .N_REQ(N_REQ), .ID_W(ID_W), .MIN_GAP_CYC(MIN_GAP), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_code(req_code),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .busy(busy), .grant_id(grant_id), .sens_request(sens_request),
    .sens_information(sens_information), .sens_done(sens_done), .fsm_state(fsm_state)
  );

  // Sensor model: drops done once a request is seen, raises it SENSOR_LAT cycles later.
  always @(negedge clock) begin
    if (sens_request == 2'b11) begin
      model_cnt = 0;
      sens_done = 1'b1;
    end else if (never_done || model_cnt < SENSOR_LAT) begin
      model_cnt++;
      sens_done = 1'b0;
    end else begin
      sens_done        = 1'b1;
      sens_information = model_data;
    end
  end

  typedef struct {
    logic [1:0] idx;
    logic [1:0] code;
    logic [7:0] data;
    logic       never;
    logic [3:0] exp_valid;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("idle_reached", 32'(busy), 0);
  endtask

  task automatic wait_pulse(inout int lat);
    while (resp_valid == '0 && lat < 400) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 1;
    wait_idle();
    model_data       = v.data;
    never_done       = v.never;
    code_in[v.idx]   = v.code;
    req_valid[v.idx] = 1'b1;
    @(negedge clock);
    check("grant_id", 32'(grant_id), 32'(v.idx));
    check("sens_req_issue", 32'(sens_request), 32'(v.code));
    if (v.code == 2'b11) req_valid[v.idx] = 1'b0;
    wait_pulse(lat);
    check("resp_latency", lat, v.exp_lat);
    check("resp_valid", 32'(resp_valid), 32'(v.exp_valid));
    check("resp_data", 32'(resp_data), 32'(v.exp_data));
    check("resp_error", 32'(resp_error), 32'(v.exp_err));
    check("sens_req_released", 32'(sens_request), 32'(2'b11));
    req_valid[v.idx] = 1'b0;
    if (v.code == 2'b11) begin
      check("no_gap_busy", 32'(busy), 0);
      @(negedge clock);
      check("pulse_one_cycle", 32'(resp_valid), 0);
    end else begin
      @(negedge clock);
      check("pulse_one_cycle", 32'(resp_valid), 0);
      repeat (18) @(negedge clock);
      check("gap_busy", 32'(busy), 1);
      @(negedge clock);
      check("gap_end_idle", 32'(busy), 0);
      check("resp_data_held", 32'(resp_data), 32'(v.exp_data));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int last_pulse;
    int extra;
    logic [3:0] order [3];

    for (int j = 0; j < N_REQ; j++) code_in[j] = 2'b00;

    vecs[0] = '{2'd1, 2'b01, 8'h1A, 1'b0, 4'b0010, 8'h1A, 1'b0, 33};
    vecs[1] = '{2'd0, 2'b00, 8'h37, 1'b0, 4'b0001, 8'h37, 1'b0, 33};
    vecs[2] = '{2'd3, 2'b10, 8'h05, 1'b0, 4'b1000, 8'h05, 1'b0, 33};
    vecs[3] = '{2'd2, 2'b10, 8'hFF, 1'b0, 4'b0100, 8'hFF, 1'b1, 33};
    vecs[4] = '{2'd0, 2'b01, 8'hFF, 1'b0, 4'b0001, 8'hFF, 1'b0, 33};
    vecs[5] = '{2'd2, 2'b11, 8'h00, 1'b0, 4'b0100, 8'hFF, 1'b1, 2};
    vecs[6] = '{2'd1, 2'b10, 8'h00, 1'b1, 4'b0010, 8'hFF, 1'b1, 102};
    vecs[7] = '{2'd3, 2'b00, 8'h00, 1'b1, 4'b1000, 8'hFF, 1'b1, 102};

    // Reset values while reset is held.
    repeat (3) @(negedge clock);
    check("rst_sens_request", 32'(sens_request), 32'(2'b11));
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_resp_error", 32'(resp_error), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_fsm_state", 32'(fsm_state), 0);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Three simultaneous requesters from reset: order 0, 2, 3 with full gaps between.
    do_reset();
    model_data = 8'h44;
    never_done = 1'b0;
    code_in[0] = 2'b00; code_in[2] = 2'b00; code_in[3] = 2'b00;
    req_valid  = 4'b1101;
    order[0] = 4'b0001; order[1] = 4'b0100; order[2] = 4'b1000;
    last_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      wait_pulse(lat);
      check("rr_order", 32'(resp_valid), 32'(order[k]));
      check("rr_data", 32'(resp_data), 32'h44);
      if (k == 0) check("rr_first_latency", lat, 33);
      else check("rr_pulse_spacing", cyc - last_pulse, 53);
      last_pulse = cyc;
      req_valid = req_valid & ~order[k];
      @(negedge clock);
    end
    check("rr_grant_held", 32'(grant_id), 3);

    // With rr pointer at 3, requester 2 beats requester 3.
    wait_idle();
    code_in[2] = 2'b01; code_in[3] = 2'b01;
    req_valid  = 4'b1100;
    @(negedge clock);
    check("rr_wrap_grant", 32'(grant_id), 2);
    for (int k = 0; k < 2; k++) begin
      lat = 0;
      wait_pulse(lat);
      check("rr_wrap_order", 32'(resp_valid), (k == 0) ? 32'(4'b0100) : 32'(4'b1000));
      req_valid = req_valid & ~resp_valid;
      @(negedge clock);
    end

    // Requester 3 drops req_valid mid-read: exactly one response still arrives.
    wait_idle();
    model_data   = 8'h6C;
    code_in[3]   = 2'b01;
    req_valid[3] = 1'b1;
    repeat (10) @(negedge clock);
    check("drop_in_wait_done", 32'(fsm_state), 2);
    req_valid[3] = 1'b0;
    lat = 10;
    wait_pulse(lat);
    check("drop_resp_valid", 32'(resp_valid), 32'(4'b1000));
    check("drop_resp_data", 32'(resp_data), 32'h6C);
    extra = 0;
    repeat (80) begin
      @(negedge clock);
      if (resp_valid != '0) extra++;
    end
    check("drop_single_pulse", extra, 0);

    // Reset during WAIT_DONE drops the read; requester 0 wins first afterwards.
    wait_idle();
    model_data   = 8'h21;
    code_in[2]   = 2'b00;
    req_valid[2] = 1'b1;
    repeat (12) @(negedge clock);
    check("rst_mid_state", 32'(fsm_state), 2);
    reset        = 1'b1;
    code_in[0]   = 2'b01;
    req_valid[0] = 1'b1;
    @(negedge clock);
    check("rst_mid_sens_request", 32'(sens_request), 32'(2'b11));
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_resp_valid", 32'(resp_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_grant", 32'(grant_id), 0);
    check("post_rst_sens_request", 32'(sens_request), 32'(2'b01));
    lat = 0;
    wait_pulse(lat);
    check("post_rst_resp0", 32'(resp_valid), 32'(4'b0001));
    check("post_rst_data0", 32'(resp_data), 32'h21);
    req_valid[0] = 1'b0;
    @(negedge clock);
    lat = 0;
    wait_pulse(lat);
    check("post_rst_resp2", 32'(resp_valid), 32'(4'b0100));
    req_valid[2] = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
